// File: rtl/pcie_st_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding the PCIe GTS p0 AXI-Stream TX port.
// Grants are locked from the first beat until the accepted tlast.
module pcie_st_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 256,
    parameter int KEEP_W    = 32,
    parameter int MAX_BEATS = 64,
    parameter int ID_W      = 2
) (
    input  logic                      p0_axi_st_clk,
    input  logic                      p0_axi_st_areset_n,
    input  logic [NUM_REQ-1:0]        req_tvalid,
    output logic [NUM_REQ-1:0]        req_tready,
    input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
    input  logic [NUM_REQ*KEEP_W-1:0] req_tkeep,
    input  logic [NUM_REQ-1:0]        req_tlast,
    input  logic [NUM_REQ-1:0]        req_enable,
    input  logic                      linkup,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic [DATA_W-1:0]         out_tdata,
    output logic [KEEP_W-1:0]         out_tkeep,
    output logic                      out_tlast,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      len_err,
    input  logic                      len_err_clr
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               len_err_q, len_err_d;

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    pick;
    logic               found;
    logic               accept;
    logic               err_set;
    int                 idx;
    int                 sel;

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        eligible = req_tvalid & req_enable & {NUM_REQ{linkup}};
        pick     = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel        = int'(grant_id_q);
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tkeep  = '0;
        out_tlast  = 1'b0;
        req_tready = '0;
        if (state_q == BUSY) begin
            out_tvalid      = req_tvalid[sel];
            out_tdata       = req_tdata[sel*DATA_W +: DATA_W];
            out_tkeep       = req_tkeep[sel*KEEP_W +: KEEP_W];
            out_tlast       = req_tlast[sel];
            req_tready[sel] = out_tready;
        end
    end

    assign accept = out_tvalid & out_tready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        err_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = pick;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    if (beat_cnt_q != CNT_W'(MAX_BEATS))
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (out_tlast) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ?
                                   '0 : grant_id_q + ID_W'(1);
                    end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
                        err_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new violation takes priority over a simultaneous clear
        len_err_d = err_set | (len_err_q & ~len_err_clr);
    end

    always_ff @(posedge p0_axi_st_clk or negedge p0_axi_st_areset_n) begin
        if (!p0_axi_st_areset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign grant_id = grant_id_q;
    assign len_err  = len_err_q;

endmodule
